player_action_fsm: RTL and testbench

Per-player action state machine that turns a player's button inputs and hit events into the current action state and animation frame index, advancing exactly once per game frame. It is the parametrised successor of the per-player next-state logic and sits between the input synchroniser and the sprite renderer / hit detection, one instance per player. It adds frame-tick gating, a self-consistent state/timer register pair, and latched hit events. It also adds configurable per-action frame counts, terminal WIN/LOSE animation and an optional attack input buffer.

---
 rtl/player_action_fsm.sv | 197 +++++++++++++++++++
 tb/tb_player_action_fsm.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/player_action_fsm.sv
// Per-player action FSM: buttons and hit events -> action state and sprite frame, stepped once per frame_tick.
// Optional attack input buffer enabled by defining PLAYER_INPUT_BUFFER_EN.
module player_action_fsm #(
    parameter int STATE_DEPTH        = 3,
    parameter int SPRITE_INDEX_DEPTH = 4,
    parameter int INPUT_DEPTH        = 5,
    parameter int KICK_FRAMES        = 6,
    parameter int GRAB_FRAMES        = 5,
    parameter int F_WALK_FRAMES      = 4,
    parameter int B_WALK_FRAMES      = 4,
    parameter int END_FRAMES         = 8,
    parameter int BUFFER_FRAMES      = 3
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic [INPUT_DEPTH-1:0]        player_buttons,
    input  logic                          player_attack_connected,
    input  logic                          opponent_attack_connected,
    output logic [STATE_DEPTH-1:0]        player_state,
    output logic [SPRITE_INDEX_DEPTH-1:0] sprite_index,
    output logic                          actionable,
    output logic                          state_valid
);
    localparam int W = SPRITE_INDEX_DEPTH;
    localparam int K_BUTTON  = 0;
    localparam int B_BUTTON  = 1;
    localparam int G_BUTTON  = 2;
    localparam int WB_BUTTON = 3;
    localparam int WF_BUTTON = 4;

    localparam logic [W-1:0] KICK_LAST = W'(KICK_FRAMES - 1);
    localparam logic [W-1:0] GRAB_LAST = W'(GRAB_FRAMES - 1);
    localparam logic [W-1:0] FWLK_LAST = W'(F_WALK_FRAMES - 1);
    localparam logic [W-1:0] BWLK_LAST = W'(B_WALK_FRAMES - 1);
    localparam logic [W-1:0] END_LAST  = W'(END_FRAMES - 1);

    if (KICK_FRAMES < 1 || KICK_FRAMES > 2**W || GRAB_FRAMES < 1 || GRAB_FRAMES > 2**W ||
        F_WALK_FRAMES < 1 || F_WALK_FRAMES > 2**W || B_WALK_FRAMES < 1 || B_WALK_FRAMES > 2**W ||
        END_FRAMES < 1 || END_FRAMES > 2**W) begin : g_bad_frames
        $error("player_action_fsm: frame count parameter out of range");
    end
    if (BUFFER_FRAMES < 1 || BUFFER_FRAMES > 15) begin : g_bad_buffer
        $error("player_action_fsm: BUFFER_FRAMES out of range");
    end

    typedef enum logic [2:0] {
        NOTHING       = 3'd0,
        WALK_FORWARD  = 3'd1,
        WALK_BACKWARD = 3'd2,
        BLOCK         = 3'd3,
        KICK          = 3'd4,
        GRAB          = 3'd5,
        WIN           = 3'd6,
        LOSE          = 3'd7
    } action_e;

    action_e        state_q, state_d;
    logic [W-1:0]   idx_q, idx_d;
    logic           act_q, act_d;
    logic           valid_q, valid_d;
    logic           win_pend_q, win_pend_d;
    logic           lose_pend_q, lose_pend_d;
    logic           win_now, lose_now;
    action_e        choice;

    function automatic logic is_actionable(input action_e s, input logic [W-1:0] idx);
        case (s)
            KICK:     is_actionable = (idx == KICK_LAST);
            GRAB:     is_actionable = (idx == GRAB_LAST);
            WIN,LOSE: is_actionable = 1'b0;
            default:  is_actionable = 1'b1;
        endcase
    endfunction

    function automatic action_e pick_button(input logic [INPUT_DEPTH-1:0] b);
        if (b[K_BUTTON])       pick_button = KICK;
        else if (b[B_BUTTON])  pick_button = BLOCK;
        else if (b[G_BUTTON])  pick_button = GRAB;
        else if (b[WB_BUTTON]) pick_button = WALK_BACKWARD;
        else if (b[WF_BUTTON]) pick_button = WALK_FORWARD;
        else                   pick_button = NOTHING;
    endfunction

    assign win_now  = win_pend_q  | player_attack_connected;
    assign lose_now = lose_pend_q | opponent_attack_connected;

`ifdef PLAYER_INPUT_BUFFER_EN
    logic       buf_valid_q, buf_valid_d;
    logic       buf_kick_q, buf_kick_d;
    logic [3:0] buf_age_q, buf_age_d;
    logic [1:0] atk_prev_q, atk_prev_d;   // {K, G} as seen at the previous tick
    logic       rise_k, rise_g;

    assign rise_k = player_buttons[K_BUTTON] & ~atk_prev_q[1];
    assign rise_g = player_buttons[G_BUTTON] & ~atk_prev_q[0];

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_kick_d  = buf_kick_q;
        buf_age_d   = buf_age_q;
        atk_prev_d  = atk_prev_q;
        choice      = pick_button(player_buttons);
        if (act_q && buf_valid_q) begin
            choice = buf_kick_q ? KICK : GRAB;
        end
        if (frame_tick) begin
            atk_prev_d = {player_buttons[K_BUTTON], player_buttons[G_BUTTON]};
            if (act_q) begin
                buf_valid_d = 1'b0;
            end else if (rise_k || rise_g) begin
                buf_valid_d = 1'b1;
                buf_kick_d  = rise_k;
                buf_age_d   = 4'd0;
            end else if (buf_valid_q) begin
                buf_age_d = buf_age_q + 4'd1;
                if (buf_age_q + 4'd1 == 4'(BUFFER_FRAMES)) buf_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_kick_q  <= 1'b0;
            buf_age_q   <= 4'd0;
            atk_prev_q  <= 2'b00;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_kick_q  <= buf_kick_d;
            buf_age_q   <= buf_age_d;
            atk_prev_q  <= atk_prev_d;
        end
    end
`else
    always_comb begin
        choice = pick_button(player_buttons);
    end
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        act_d       = act_q;
        valid_d     = 1'b0;
        win_pend_d  = win_pend_q  | player_attack_connected;
        lose_pend_d = lose_pend_q | opponent_attack_connected;
        if (frame_tick) begin
            valid_d     = 1'b1;
            win_pend_d  = 1'b0;
            lose_pend_d = 1'b0;
            if (state_q == WIN || state_q == LOSE) begin
                idx_d = (idx_q == END_LAST) ? idx_q : idx_q + 1'b1;
            end else if (win_now) begin
                state_d = WIN;
                idx_d   = '0;
            end else if (lose_now) begin
                state_d = LOSE;
                idx_d   = '0;
            end else if (act_q) begin
                // Only continuing walks keep counting; everything else (incl. re-kick) restarts at 0.
                state_d = choice;
                idx_d   = '0;
                if (choice == state_q && choice == WALK_FORWARD)
                    idx_d = (idx_q == FWLK_LAST) ? '0 : idx_q + 1'b1;
                else if (choice == state_q && choice == WALK_BACKWARD)
                    idx_d = (idx_q == BWLK_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
            act_d = is_actionable(state_d, idx_d);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= NOTHING;
            idx_q       <= '0;
            act_q       <= 1'b1;
            valid_q     <= 1'b0;
            win_pend_q  <= 1'b0;
            lose_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            act_q       <= act_d;
            valid_q     <= valid_d;
            win_pend_q  <= win_pend_d;
            lose_pend_q <= lose_pend_d;
        end
    end

    assign player_state = STATE_DEPTH'(state_q);
    assign sprite_index = idx_q;
    assign actionable   = act_q;
    assign state_valid  = valid_q;
endmodule

// File: tb/tb_player_action_fsm.sv
// Directed table-driven bench for player_action_fsm with default parameters.
// Expected values are hand-derived; the attack-buffer case follows PLAYER_INPUT_BUFFER_EN.
module tb_player_action_fsm;
    localparam logic [2:0] S_NOTHING = 3'd0, S_WF = 3'd1, S_WB = 3'd2, S_BLOCK = 3'd3,
                           S_KICK = 3'd4, S_GRAB = 3'd5, S_WIN = 3'd6, S_LOSE = 3'd7;
    localparam logic [4:0] BK = 5'b00001, BB = 5'b00010, BG = 5'b00100,
                           BWB = 5'b01000, BWF = 5'b10000, B0 = 5'b00000;

    typedef struct {
        logic       rst;
        logic       tick;
        logic [4:0] btn;
        logic       pa;
        logic       oa;
        logic [2:0] st;
        logic [3:0] idx;
        logic       act;
        logic       vld;
    } vec_t;

    vec_t vecs[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [4:0] player_buttons = '0;
    logic       player_attack_connected = 1'b0;
    logic       opponent_attack_connected = 1'b0;
    logic [2:0] player_state;
    logic [3:0] sprite_index;
    logic       actionable;
    logic       state_valid;

    int n_cmp = 0;
    int n_bad = 0;

    player_action_fsm dut (
        .sys_clk                   (clk),
        .reset                     (reset),
        .frame_tick                (frame_tick),
        .player_buttons            (player_buttons),
        .player_attack_connected   (player_attack_connected),
        .opponent_attack_connected (opponent_attack_connected),
        .player_state              (player_state),
        .sprite_index              (sprite_index),
        .actionable                (actionable),
        .state_valid               (state_valid)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic tick, input logic [4:0] btn,
                       input logic pa, input logic oa, input logic [2:0] st,
                       input logic [3:0] idx, input logic act, input logic vld);
        vec_t v;
        v.rst = rst; v.tick = tick; v.btn = btn; v.pa = pa; v.oa = oa;
        v.st = st; v.idx = idx; v.act = act; v.vld = vld;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then compare {state, idx, actionable, valid} just after the edge.
    task automatic step(input string name, input logic rst, input logic tick, input logic [4:0] btn,
                        input logic pa, input logic oa, input logic [2:0] st,
                        input logic [3:0] idx, input logic act, input logic vld);
        logic [8:0] got, exp;
        reset = rst; frame_tick = tick; player_buttons = btn;
        player_attack_connected = pa; opponent_attack_connected = oa;
        @(posedge clk);
        #1;
        got = {player_state, sprite_index, actionable, state_valid};
        exp = {st, idx, act, vld};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got state=%0d idx=%0d act=%b valid=%b, expected state=%0d idx=%0d act=%b valid=%b",
                     name, player_state, sprite_index, actionable, state_valid, st, idx, act, vld);
        end else begin
            $display("ok   %s: state=%0d idx=%0d act=%b valid=%b", name, st, idx, act, vld);
        end
    endtask

    initial begin
        // Kick timing, re-kick, no update without tick, B over G.
        add(1, 0, B0, 0, 0, S_NOTHING, 0, 1, 0);
        for (int i = 0; i < 6; i++) add(0, 1, BK, 0, 0, S_KICK, 4'(i), i == 5, 1);
        add(0, 1, BK, 0, 0, S_KICK, 0, 0, 1);
        add(0, 0, BK, 0, 0, S_KICK, 0, 0, 0);
        for (int i = 1; i < 6; i++) add(0, 1, B0, 0, 0, S_KICK, 4'(i), i == 5, 1);
        add(0, 1, BB | BG, 0, 0, S_BLOCK, 0, 1, 1);
        add(0, 1, BG | BWB, 0, 0, S_GRAB, 0, 0, 1);
        // Walk loop and walk priority.
        add(1, 0, B0, 0, 0, S_NOTHING, 0, 1, 0);
        for (int i = 0; i < 9; i++) add(0, 1, BWF, 0, 0, S_WF, 4'(i % 4), 1, 1);
        add(0, 0, BWF, 0, 0, S_WF, 0, 1, 0);
        add(0, 1, BWF | BWB, 0, 0, S_WB, 0, 1, 1);
        add(0, 1, BWB, 0, 0, S_WB, 1, 1, 1);
        add(0, 1, B0, 0, 0, S_NOTHING, 0, 1, 1);
        add(0, 0, B0, 0, 0, S_NOTHING, 0, 1, 0);
        // Opponent hit between ticks mid-kick, LOSE saturation, terminal.
        add(0, 1, BK, 0, 0, S_KICK, 0, 0, 1);
        add(0, 1, BK, 0, 0, S_KICK, 1, 0, 1);
        add(0, 1, B0, 0, 0, S_KICK, 2, 0, 1);
        add(0, 0, B0, 0, 1, S_KICK, 2, 0, 0);
        add(0, 0, B0, 0, 0, S_KICK, 2, 0, 0);
        add(0, 1, BWF, 0, 0, S_LOSE, 0, 0, 1);
        for (int i = 1; i <= 12; i++) add(0, 1, BK, 0, 0, S_LOSE, 4'(i > 7 ? 7 : i), 0, 1);
        add(0, 1, BK, 1, 0, S_LOSE, 7, 0, 1);
        // Both hits latched -> WIN; reset beats a tick mid-WIN.
        add(1, 0, B0, 0, 0, S_NOTHING, 0, 1, 0);
        add(0, 0, B0, 1, 0, S_NOTHING, 0, 1, 0);
        add(0, 0, B0, 0, 1, S_NOTHING, 0, 1, 0);
        add(0, 1, BK, 0, 0, S_WIN, 0, 0, 1);
        add(0, 1, BK, 0, 0, S_WIN, 1, 0, 1);
        add(1, 1, BK, 0, 0, S_NOTHING, 0, 1, 0);
        // Hit in the tick cycle itself; grab timing and re-grab.
        add(0, 1, BK, 0, 1, S_LOSE, 0, 0, 1);
        add(1, 0, B0, 0, 0, S_NOTHING, 0, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 1, BG, 0, 0, S_GRAB, 4'(i), i == 4, 1);
        add(0, 1, BG, 0, 0, S_GRAB, 0, 0, 1);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].tick, vecs[i].btn, vecs[i].pa,
                 vecs[i].oa, vecs[i].st, vecs[i].idx, vecs[i].act, vecs[i].vld);
        end

        // Grab pressed at kick idx 3 then released.
        step("buf_rst", 1, 0, B0, 0, 0, S_NOTHING, 0, 1, 0);
        step("buf_k0", 0, 1, BK, 0, 0, S_KICK, 0, 0, 1);
        step("buf_k1", 0, 1, B0, 0, 0, S_KICK, 1, 0, 1);
        step("buf_k2", 0, 1, B0, 0, 0, S_KICK, 2, 0, 1);
        step("buf_k3", 0, 1, B0, 0, 0, S_KICK, 3, 0, 1);
        step("buf_k4", 0, 1, BG, 0, 0, S_KICK, 4, 0, 1);
        step("buf_k5", 0, 1, B0, 0, 0, S_KICK, 5, 1, 1);
`ifdef PLAYER_INPUT_BUFFER_EN
        step("buf_use", 0, 1, B0, 0, 0, S_GRAB, 0, 0, 1);
`else
        step("buf_use", 0, 1, B0, 0, 0, S_NOTHING, 0, 1, 1);
`endif
        step("buf_idle", 0, 0, B0, 0, 0,
`ifdef PLAYER_INPUT_BUFFER_EN
             S_GRAB, 0, 0, 0);
`else
             S_NOTHING, 0, 1, 0);
`endif
        // Grab pressed at kick idx 1 expires before the kick ends.
        step("exp_rst", 1, 0, B0, 0, 0, S_NOTHING, 0, 1, 0);
        step("exp_k0", 0, 1, BK, 0, 0, S_KICK, 0, 0, 1);
        step("exp_k1", 0, 1, B0, 0, 0, S_KICK, 1, 0, 1);
        step("exp_k2", 0, 1, BG, 0, 0, S_KICK, 2, 0, 1);
        step("exp_k3", 0, 1, B0, 0, 0, S_KICK, 3, 0, 1);
        step("exp_k4", 0, 1, B0, 0, 0, S_KICK, 4, 0, 1);
        step("exp_k5", 0, 1, B0, 0, 0, S_KICK, 5, 1, 1);
        step("exp_end", 0, 1, B0, 0, 0, S_NOTHING, 0, 1, 1);
        step("exp_idle", 0, 0, B0, 0, 0, S_NOTHING, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
